// File: rtl/code_lock_ctrl.sv
// Keypad code lock: digit entry with verdict on the last key, timed unlock,
// lockout after repeated failures, and reprogramming of the code while open.
module code_lock_ctrl #(
  parameter int                       DIGITS         = 3,
  parameter int                       KEY_W          = 4,
  parameter logic [DIGITS*KEY_W-1:0]  DEFAULT_CODE   = 12'h789,
  parameter int                       MAX_ERR        = 3,
  parameter int                       OPEN_CYCLES    = 1000,
  parameter int                       PENALTY_CYCLES = 5000,
  parameter int                       TIMEOUT_CYCLES = 2000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key,
  input  logic             key_valid,
  input  logic             relock,
  output logic             unlock,
  output logic             error,
  output logic             lockout,
  output logic [3:0]       err_count,
  output logic             prog_active,
  output logic             prog_done,
  output logic [1:0]       state_dbg
);

  localparam int MAX_AB = (OPEN_CYCLES > PENALTY_CYCLES) ? OPEN_CYCLES : PENALTY_CYCLES;
  localparam int MAX_C  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int TW     = $clog2(MAX_C) + 1;
  localparam int BW     = (DIGITS - 1) * KEY_W;
  localparam int IW     = $clog2(DIGITS + 1);

  localparam logic [KEY_W-1:0] K_PROG  = KEY_W'(10);
  localparam logic [KEY_W-1:0] K_CLEAR = KEY_W'(11);
  localparam logic [KEY_W-1:0] K_MAXD  = KEY_W'(9);

  // state_dbg encoding: 0 ENTRY, 1 OPEN, 2 PENALTY, 3 PROG
  typedef enum logic [1:0] {
    S_ENTRY   = 2'd0,
    S_OPEN    = 2'd1,
    S_PENALTY = 2'd2,
    S_PROG    = 2'd3
  } state_t;

  state_t                  state;
  logic [DIGITS*KEY_W-1:0] code;
  logic [BW-1:0]           key_buf;
  logic [IW-1:0]           idx;
  logic [TW-1:0]           timer;
  logic                    run;

  // key_valid is a one-cycle strobe with no back-pressure: key is consumed
  // on the rising edge where key_valid=1, or dropped if the current state
  // (or a simultaneous timer expiry / relock) ignores it.
  logic kv, tmo, last_key, is_digit;
  assign kv       = key_valid & run;
  assign tmo      = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign last_key = (idx == IW'(DIGITS - 1));
  assign is_digit = (key <= K_MAXD);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_ENTRY;
      code        <= DEFAULT_CODE;
      key_buf     <= '0;
      idx         <= '0;
      timer       <= '0;
      run         <= 1'b0;
      unlock      <= 1'b0;
      error       <= 1'b0;
      lockout     <= 1'b0;
      err_count   <= 4'd0;
      prog_active <= 1'b0;
      prog_done   <= 1'b0;
    end else begin
      // The first edge after reset release only arms key acceptance.
      run       <= 1'b1;
      error     <= 1'b0;
      prog_done <= 1'b0;
      case (state)
        S_ENTRY: begin
          if (idx != '0 && tmo) begin
            idx   <= '0;
            timer <= '0;
          end else if (kv) begin
            timer <= '0;
            if (key == K_CLEAR) begin
              idx <= '0;
            end else if (key != K_PROG) begin
              if (last_key) begin
                idx <= '0;
                if ({key_buf, key} == code) begin
                  state     <= S_OPEN;
                  unlock    <= 1'b1;
                  err_count <= 4'd0;
                end else begin
                  error <= 1'b1;
                  if (err_count >= 4'(MAX_ERR - 1)) begin
                    err_count <= 4'(MAX_ERR);
                    state     <= S_PENALTY;
                    lockout   <= 1'b1;
                  end else begin
                    err_count <= err_count + 4'd1;
                  end
                end
              end else begin
                key_buf <= BW'({key_buf, key});
                idx     <= idx + IW'(1);
              end
            end
          end else if (idx != '0) begin
            timer <= timer + TW'(1);
          end
        end
        S_OPEN: begin
          if (relock || timer == TW'(OPEN_CYCLES - 1)) begin
            state  <= S_ENTRY;
            unlock <= 1'b0;
            timer  <= '0;
          end else if (kv && key == K_PROG) begin
            state       <= S_PROG;
            unlock      <= 1'b0;
            prog_active <= 1'b1;
            timer       <= '0;
            idx         <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_PROG: begin
          if (relock || tmo || (kv && !is_digit)) begin
            state       <= S_ENTRY;
            prog_active <= 1'b0;
            timer       <= '0;
            idx         <= '0;
          end else if (kv) begin
            timer <= '0;
            if (last_key) begin
              code        <= {key_buf, key};
              prog_done   <= 1'b1;
              state       <= S_ENTRY;
              prog_active <= 1'b0;
              idx         <= '0;
            end else begin
              key_buf <= BW'({key_buf, key});
              idx     <= idx + IW'(1);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_PENALTY: begin
          if (timer == TW'(PENALTY_CYCLES - 1)) begin
            state     <= S_ENTRY;
            lockout   <= 1'b0;
            err_count <= 4'd0;
            timer     <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= S_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: directed scenarios plus a randomized run, all
// checked against a queue/countdown model of the lock's rules.
module tb_code_lock_ctrl;

  localparam int DIG  = 3;
  localparam int MAXE = 3;
  localparam int OPN  = 1000;
  localparam int PEN  = 5000;
  localparam int TMO  = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key = 4'd0;
  logic       key_valid = 1'b0;
  logic       relock = 1'b0;
  logic       unlock, error, lockout, prog_active, prog_done;
  logic [3:0] err_count;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  code_lock_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .relock(relock),
    .unlock(unlock), .error(error), .lockout(lockout), .err_count(err_count),
    .prog_active(prog_active), .prog_done(prog_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // mode: 0 ENTRY, 1 OPEN, 2 PENALTY, 3 PROG
  int m_mode, m_left, m_quiet, m_err;
  int ent_q[$];
  int prg_q[$];
  int code_q[$];
  bit e_unlock, e_error, e_lockout, e_pa, e_pd;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_quiet = 0; m_err = 0;
    ent_q.delete(); prg_q.delete();
    code_q = '{7, 8, 9};
    e_unlock = 0; e_error = 0; e_lockout = 0; e_pa = 0; e_pd = 0;
  endtask

  task automatic model_step(input bit kv, input int k, input bit rl);
    bit same;
    e_error = 0;
    e_pd = 0;
    case (m_mode)
      0: begin
        if (ent_q.size() > 0 && m_quiet == TMO - 1) begin
          ent_q.delete();
          m_quiet = 0;
        end else if (kv) begin
          m_quiet = 0;
          if (k == 11) ent_q.delete();
          else if (k != 10) begin
            ent_q.push_back(k);
            if (ent_q.size() == DIG) begin
              same = 1;
              for (int i = 0; i < DIG; i++) if (ent_q[i] != code_q[i]) same = 0;
              if (same) begin
                m_mode = 1; m_left = OPN; e_unlock = 1; m_err = 0;
              end else begin
                e_error = 1;
                m_err = (m_err + 1 > MAXE) ? MAXE : m_err + 1;
                if (m_err == MAXE) begin
                  m_mode = 2; m_left = PEN; e_lockout = 1;
                end
              end
              ent_q.delete();
            end
          end
        end else if (ent_q.size() > 0) m_quiet++;
      end
      1: begin
        if (rl || m_left == 1) begin
          m_mode = 0; e_unlock = 0;
        end else if (kv && k == 10) begin
          m_mode = 3; e_unlock = 0; e_pa = 1; prg_q.delete(); m_quiet = 0;
        end else m_left--;
      end
      3: begin
        if (rl || m_quiet == TMO - 1 || (kv && k > 9)) begin
          m_mode = 0; e_pa = 0;
        end else if (kv) begin
          prg_q.push_back(k);
          m_quiet = 0;
          if (prg_q.size() == DIG) begin
            code_q = prg_q; e_pd = 1; m_mode = 0; e_pa = 0;
          end
        end else m_quiet++;
      end
      default: begin
        if (m_left == 1) begin
          m_mode = 0; e_lockout = 0; m_err = 0;
        end else m_left--;
      end
    endcase
  endtask

  function automatic logic [10:0] obs();
    return {unlock, error, lockout, prog_active, prog_done, err_count, state_dbg};
  endfunction

  function automatic logic [10:0] expv();
    return {e_unlock, e_error, e_lockout, e_pa, e_pd, 4'(m_err), 2'(m_mode)};
  endfunction

  // ---------------- drivers ----------------
  task automatic tick(input bit kv, input int k, input bit rl);
    @(negedge clk);
    key_valid = kv; key = 4'(k); relock = rl;
    @(posedge clk);
    #1;
    model_step(kv, k, rl);
  endtask

  task automatic press(input int k);
    tick(1'b1, k, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; key_valid = 1'b0; relock = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (obs() !== 11'd0) begin
      n_bad++; $display("FAIL reset_state: got %b want %b", obs(), 11'd0);
    end
  endtask

  task automatic test_unlock();
    press(7); press(8); press(9);
    n_cmp++;
    if (unlock !== 1'b1 || obs() !== expv()) begin
      n_bad++; $display("FAIL unlock_rise: got %b want %b", obs(), expv());
    end
    idle(OPN - 1);
    n_cmp++;
    if (unlock !== 1'b1) begin
      n_bad++; $display("FAIL unlock_hold: unlock=%b want 1", unlock);
    end
    idle(1);
    n_cmp++;
    if (unlock !== 1'b0 || err_count !== 4'd0 || obs() !== expv()) begin
      n_bad++; $display("FAIL unlock_expire: got %b want %b", obs(), expv());
    end
  endtask

  task automatic test_lockout();
    for (int a = 1; a <= 3; a++) begin
      press(7); press(1); press(9);
      n_cmp++;
      if (error !== 1'b1 || err_count !== 4'(a) || lockout !== (a == 3)) begin
        n_bad++; $display("FAIL attempt_%0d: err=%b cnt=%0d lock=%b", a, error, err_count, lockout);
      end
    end
    idle(1);
    n_cmp++;
    if (error !== 1'b0 || lockout !== 1'b1) begin
      n_bad++; $display("FAIL error_pulse_width: err=%b lock=%b want 0 1", error, lockout);
    end
    press(7); press(8); press(9);
    n_cmp++;
    if (unlock !== 1'b0 || lockout !== 1'b1) begin
      n_bad++; $display("FAIL key_in_penalty: unlock=%b lock=%b want 0 1", unlock, lockout);
    end
    idle(PEN - 5);
    n_cmp++;
    if (lockout !== 1'b1) begin
      n_bad++; $display("FAIL penalty_hold: lockout=%b want 1", lockout);
    end
    idle(1);
    n_cmp++;
    if (lockout !== 1'b0 || err_count !== 4'd0 || obs() !== expv()) begin
      n_bad++; $display("FAIL penalty_end: got %b want %b", obs(), expv());
    end
  endtask

  task automatic test_timeout();
    press(7); press(8);
    idle(TMO);
    press(7); press(8); press(9);
    n_cmp++;
    if (unlock !== 1'b1 || error !== 1'b0 || obs() !== expv()) begin
      n_bad++; $display("FAIL partial_timeout: got %b want %b", obs(), expv());
    end
    tick(1'b0, 0, 1'b1);
    n_cmp++;
    if (unlock !== 1'b0) begin
      n_bad++; $display("FAIL relock: unlock=%b want 0", unlock);
    end
  endtask

  task automatic test_prog();
    press(7); press(8); press(9);
    press(10);
    n_cmp++;
    if (prog_active !== 1'b1 || unlock !== 1'b0) begin
      n_bad++; $display("FAIL prog_enter: pa=%b unlock=%b want 1 0", prog_active, unlock);
    end
    press(1); press(2); press(3);
    n_cmp++;
    if (prog_done !== 1'b1 || state_dbg !== 2'd0 || prog_active !== 1'b0) begin
      n_bad++; $display("FAIL prog_commit: pd=%b st=%0d pa=%b want 1 0 0", prog_done, state_dbg, prog_active);
    end
    idle(1);
    n_cmp++;
    if (prog_done !== 1'b0) begin
      n_bad++; $display("FAIL prog_done_width: pd=%b want 0", prog_done);
    end
    press(7); press(8); press(9);
    n_cmp++;
    if (error !== 1'b1 || err_count !== 4'd1) begin
      n_bad++; $display("FAIL old_code_rejected: err=%b cnt=%0d want 1 1", error, err_count);
    end
    press(1); press(2); press(3);
    n_cmp++;
    if (unlock !== 1'b1 || err_count !== 4'd0 || obs() !== expv()) begin
      n_bad++; $display("FAIL new_code_opens: got %b want %b", obs(), expv());
    end
    tick(1'b0, 0, 1'b1);
  endtask

  task automatic test_prog_abort();
    apply_reset();
    press(7); press(8); press(9);
    press(10); press(1);
    tick(1'b0, 0, 1'b1);
    n_cmp++;
    if (prog_active !== 1'b0 || prog_done !== 1'b0 || state_dbg !== 2'd0) begin
      n_bad++; $display("FAIL prog_abort: pa=%b pd=%b st=%0d want 0 0 0", prog_active, prog_done, state_dbg);
    end
    press(7); press(8); press(9);
    n_cmp++;
    if (unlock !== 1'b1) begin
      n_bad++; $display("FAIL code_kept: unlock=%b want 1", unlock);
    end
    tick(1'b1, 10, 1'b1);
    n_cmp++;
    if (unlock !== 1'b0 || prog_active !== 1'b0 || obs() !== expv()) begin
      n_bad++; $display("FAIL relock_beats_key: got %b want %b", obs(), expv());
    end
  endtask

  task automatic test_reset_mid_prog();
    press(7); press(8); press(9);
    press(10); press(4); press(5); press(6);
    press(4); press(5); press(6);
    press(10); press(1); press(2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 11'd0) begin
      n_bad++; $display("FAIL async_reset: got %b want %b", obs(), 11'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    press(4); press(5); press(6);
    n_cmp++;
    if (error !== 1'b1 || unlock !== 1'b0) begin
      n_bad++; $display("FAIL code_reverted: err=%b unlock=%b want 1 0", error, unlock);
    end
    press(7); press(8); press(9);
    n_cmp++;
    if (unlock !== 1'b1 || obs() !== expv()) begin
      n_bad++; $display("FAIL default_opens: got %b want %b", obs(), expv());
    end
  endtask

  task automatic test_random();
    int bad_here;
    int k;
    bit kv, rl;
    apply_reset();
    bad_here = 0;
    for (int c = 0; c < 6000; c++) begin
      kv = ($urandom_range(0, 2) == 0);
      rl = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: k = (ent_q.size() < DIG) ? code_q[ent_q.size()] : 7;
        6: k = 10;
        7: k = 11;
        default: k = $urandom_range(0, 15);
      endcase
      tick(kv, k, rl);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++;
        bad_here++;
        if (bad_here <= 5)
          $display("FAIL random_cycle_%0d: got %b want %b", c, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_timeout();
    test_prog();
    test_prog_abort();
    test_reset_mid_prog();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
